// File: rtl/wb_regfile.sv
// wb_regfile: one-deep WB stage committing EX results into a 32x32 register file with EX/WB forwarding
//   clk, rstn                  : rising-edge clock, asynchronous active-low reset
//   RegWrite{En,Addr,Data}_i   : EX result triple; stall holds it uncaptured, flush discards it
//   rd_addr1/2 -> rd_data1/2   : combinational read ports, $0 reads zero, newest value wins
//   wb_en_o, wb_addr_o         : WB stage state for the hazard unit
//   WB_REGFILE_COMMIT_CNT_EN   : when defined, adds commit_cnt counting real commits (wraps)
module wb_regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          RegWriteEn_i,
  input  logic [AW-1:0] RegWriteAddr_i,
  input  logic [DW-1:0] RegWriteData_i,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic          wb_en_o,
  output logic [AW-1:0] wb_addr_o
`ifdef WB_REGFILE_COMMIT_CNT_EN
  ,
  output logic [31:0]   commit_cnt
`endif
);
  logic          wb_en_q, wb_en_d, commit;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [DW-1:0] regs_q [2**AW];
  // wb_en_d doubles as the EX-forward qualifier: only a result that will be captured is forwarded
  always_comb begin
    wb_en_d   = RegWriteEn_i && !stall && !flush;
    wb_addr_d = RegWriteAddr_i;
    wb_data_d = RegWriteData_i;
    commit    = wb_en_q && wb_addr_q != '0;
    rd_data1  = rd_addr1 == '0 ? '0 :
                wb_en_d && RegWriteAddr_i == rd_addr1 ? RegWriteData_i :
                wb_en_q && wb_addr_q == rd_addr1 ? wb_data_q : regs_q[rd_addr1];
    rd_data2  = rd_addr2 == '0 ? '0 :
                wb_en_d && RegWriteAddr_i == rd_addr2 ? RegWriteData_i :
                wb_en_q && wb_addr_q == rd_addr2 ? wb_data_q : regs_q[rd_addr2];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2**AW; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[wb_addr_q] <= wb_data_q;
    end
  end
  assign wb_en_o   = wb_en_q;
  assign wb_addr_o = wb_addr_q;
`ifdef WB_REGFILE_COMMIT_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + 32'(commit);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign commit_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile forwarding, commit, stall, flush and reset
module tb_wb_regfile;
  localparam int DW = 32, AW = 5;
  logic clk = 1'b0, rstn = 1'b0;
  logic en = 1'b0, st = 1'b0, fl = 1'b0;
  logic [AW-1:0] wa = '0, ra1 = '0, ra2 = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] rd1, rd2;
  logic wb_en;
  logic [AW-1:0] wb_addr;
`ifdef WB_REGFILE_COMMIT_CNT_EN
  logic [31:0] cnt;
`endif
  int tests = 0, fails = 0;
  int unsigned exp_cnt = 0;
  typedef struct {logic [DW-1:0] r1; logic [DW-1:0] r2; logic we;} exp_t;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  wb_regfile #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .RegWriteEn_i(en), .RegWriteAddr_i(wa), .RegWriteData_i(wd),
    .stall(st), .flush(fl),
    .rd_addr1(ra1), .rd_addr2(ra2), .rd_data1(rd1), .rd_data2(rd2),
    .wb_en_o(wb_en), .wb_addr_o(wb_addr)
`ifdef WB_REGFILE_COMMIT_CNT_EN
    , .commit_cnt(cnt)
`endif
  );
  task automatic drive(input int e_, input int a, input logic [DW-1:0] d, input int s, input int f,
                       input int r1, input int r2);
    @(posedge clk);
    #1;
    en = 1'(e_); wa = AW'(a); wd = d; st = 1'(s); fl = 1'(f); ra1 = AW'(r1); ra2 = AW'(r2);
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    #12;
    rstn = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ra1 = AW'(a); ra2 = AW'(31 - a);
      sb.push_back('{32'h0, 32'h0, 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      tests += 3;
      if (rd1 !== e.r1) begin fails++; $display("FAIL reset rd1 a=%0d got %h exp %h", a, rd1, e.r1); end
      if (rd2 !== e.r2) begin fails++; $display("FAIL reset rd2 a=%0d got %h exp %h", 31 - a, rd2, e.r2); end
      if (wb_en !== e.we) begin fails++; $display("FAIL reset wb_en got %b exp %b", wb_en, e.we); end
    end
  endtask
  task automatic test_forward;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drive(1, 5, 32'h12345678, 0, 0, 5, 0); sb.push_back('{32'h12345678, 32'h0, 1'b0}); end
        1: begin drive(0, 5, 32'hDEADBEEF, 0, 0, 5, 5); sb.push_back('{32'h12345678, 32'h12345678, 1'b1}); end
        default: begin drive(0, 0, 32'h0, 0, 0, 5, 5); sb.push_back('{32'h12345678, 32'h12345678, 1'b0}); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests += 3;
      if (rd1 !== e.r1) begin fails++; $display("FAIL fwd rd1 c%0d got %h exp %h", c, rd1, e.r1); end
      if (rd2 !== e.r2) begin fails++; $display("FAIL fwd rd2 c%0d got %h exp %h", c, rd2, e.r2); end
      if (wb_en !== e.we) begin fails++; $display("FAIL fwd wb_en c%0d got %b exp %b", c, wb_en, e.we); end
      if (c == 1) begin
        tests++;
        if (wb_addr !== 5'd5) begin fails++; $display("FAIL fwd wb_addr got %0d exp 5", wb_addr); end
      end
    end
    exp_cnt++;
`ifdef WB_REGFILE_COMMIT_CNT_EN
    tests++;
    if (cnt !== exp_cnt) begin fails++; $display("FAIL fwd commit_cnt got %0d exp %0d", cnt, exp_cnt); end
`endif
  endtask
  task automatic test_zero;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0); sb.push_back('{32'h0, 32'h0, 1'b0}); end
        1: begin drive(0, 0, 32'hFFFFFFFF, 0, 0, 0, 0); sb.push_back('{32'h0, 32'h0, 1'b1}); end
        default: begin drive(0, 0, 32'h0, 0, 0, 0, 0); sb.push_back('{32'h0, 32'h0, 1'b0}); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests += 3;
      if (rd1 !== e.r1) begin fails++; $display("FAIL zero rd1 c%0d got %h exp %h", c, rd1, e.r1); end
      if (rd2 !== e.r2) begin fails++; $display("FAIL zero rd2 c%0d got %h exp %h", c, rd2, e.r2); end
      if (wb_en !== e.we) begin fails++; $display("FAIL zero wb_en c%0d got %b exp %b", c, wb_en, e.we); end
    end
`ifdef WB_REGFILE_COMMIT_CNT_EN
    tests++;
    if (cnt !== exp_cnt) begin fails++; $display("FAIL zero commit_cnt got %0d exp %0d", cnt, exp_cnt); end
`endif
  endtask
  task automatic test_back_to_back;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin drive(1, 7, 32'hA, 0, 0, 5, 7); sb.push_back('{32'h12345678, 32'hA, 1'b0}); end
        1: begin drive(1, 7, 32'hB, 0, 0, 5, 7); sb.push_back('{32'h12345678, 32'hB, 1'b1}); end
        2: begin drive(0, 7, 32'hC, 0, 0, 5, 7); sb.push_back('{32'h12345678, 32'hB, 1'b1}); end
        default: begin drive(0, 0, 32'h0, 0, 0, 5, 7); sb.push_back('{32'h12345678, 32'hB, 1'b0}); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests += 3;
      if (rd1 !== e.r1) begin fails++; $display("FAIL b2b rd1 c%0d got %h exp %h", c, rd1, e.r1); end
      if (rd2 !== e.r2) begin fails++; $display("FAIL b2b rd2 c%0d got %h exp %h", c, rd2, e.r2); end
      if (wb_en !== e.we) begin fails++; $display("FAIL b2b wb_en c%0d got %b exp %b", c, wb_en, e.we); end
    end
    exp_cnt += 2;
`ifdef WB_REGFILE_COMMIT_CNT_EN
    tests++;
    if (cnt !== exp_cnt) begin fails++; $display("FAIL b2b commit_cnt got %0d exp %0d", cnt, exp_cnt); end
`endif
  endtask
  task automatic test_stall;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0, 1, 2: begin drive(1, 9, 32'h55, 1, 0, 9, 7); sb.push_back('{32'h0, 32'hB, 1'b0}); end
        3: begin drive(1, 9, 32'h55, 0, 0, 9, 7); sb.push_back('{32'h55, 32'hB, 1'b0}); end
        4: begin drive(0, 9, 32'h55, 0, 0, 9, 7); sb.push_back('{32'h55, 32'hB, 1'b1}); end
        default: begin drive(0, 0, 32'h0, 0, 0, 9, 7); sb.push_back('{32'h55, 32'hB, 1'b0}); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests += 3;
      if (rd1 !== e.r1) begin fails++; $display("FAIL stall rd1 c%0d got %h exp %h", c, rd1, e.r1); end
      if (rd2 !== e.r2) begin fails++; $display("FAIL stall rd2 c%0d got %h exp %h", c, rd2, e.r2); end
      if (wb_en !== e.we) begin fails++; $display("FAIL stall wb_en c%0d got %b exp %b", c, wb_en, e.we); end
      if (c == 4) begin
        tests++;
        if (wb_addr !== 5'd9) begin fails++; $display("FAIL stall wb_addr got %0d exp 9", wb_addr); end
      end
    end
    exp_cnt++;
`ifdef WB_REGFILE_COMMIT_CNT_EN
    tests++;
    if (cnt !== exp_cnt) begin fails++; $display("FAIL stall commit_cnt got %0d exp %0d", cnt, exp_cnt); end
`endif
  endtask
  task automatic test_flush;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin drive(1, 3, 32'h77, 0, 1, 3, 9); sb.push_back('{32'h0, 32'h55, 1'b0}); end
        1: begin drive(1, 3, 32'h77, 1, 1, 3, 9); sb.push_back('{32'h0, 32'h55, 1'b0}); end
        2: begin drive(0, 3, 32'h77, 0, 0, 3, 9); sb.push_back('{32'h0, 32'h55, 1'b0}); end
        default: begin drive(0, 0, 32'h0, 0, 0, 3, 9); sb.push_back('{32'h0, 32'h55, 1'b0}); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests += 3;
      if (rd1 !== e.r1) begin fails++; $display("FAIL flush rd1 c%0d got %h exp %h", c, rd1, e.r1); end
      if (rd2 !== e.r2) begin fails++; $display("FAIL flush rd2 c%0d got %h exp %h", c, rd2, e.r2); end
      if (wb_en !== e.we) begin fails++; $display("FAIL flush wb_en c%0d got %b exp %b", c, wb_en, e.we); end
    end
`ifdef WB_REGFILE_COMMIT_CNT_EN
    tests++;
    if (cnt !== exp_cnt) begin fails++; $display("FAIL flush commit_cnt got %0d exp %0d", cnt, exp_cnt); end
`endif
  endtask
  task automatic test_overflow;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) drive(0, 4, 32'h80000000, 0, 0, 4, 4);
      else drive(0, 0, 32'h0, 0, 0, 4, 4);
      sb.push_back('{32'h0, 32'h0, 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      tests += 3;
      if (rd1 !== e.r1) begin fails++; $display("FAIL ovf rd1 c%0d got %h exp %h", c, rd1, e.r1); end
      if (rd2 !== e.r2) begin fails++; $display("FAIL ovf rd2 c%0d got %h exp %h", c, rd2, e.r2); end
      if (wb_en !== e.we) begin fails++; $display("FAIL ovf wb_en c%0d got %b exp %b", c, wb_en, e.we); end
    end
  endtask
  task automatic test_reset_mid;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drive(1, 10, 32'hCAFEF00D, 0, 0, 10, 5); sb.push_back('{32'hCAFEF00D, 32'h12345678, 1'b0}); end
        1: begin drive(0, 10, 32'h0, 0, 0, 10, 5); sb.push_back('{32'hCAFEF00D, 32'h12345678, 1'b1}); end
        default: begin drive(0, 0, 32'h0, 0, 0, 10, 5); sb.push_back('{32'h0, 32'h0, 1'b0}); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests += 3;
      if (rd1 !== e.r1) begin fails++; $display("FAIL rstmid rd1 c%0d got %h exp %h", c, rd1, e.r1); end
      if (rd2 !== e.r2) begin fails++; $display("FAIL rstmid rd2 c%0d got %h exp %h", c, rd2, e.r2); end
      if (wb_en !== e.we) begin fails++; $display("FAIL rstmid wb_en c%0d got %b exp %b", c, wb_en, e.we); end
      if (c == 1) begin
        rstn = 1'b0;
        #2;
        tests += 3;
        if (rd1 !== 32'h0) begin fails++; $display("FAIL rstmid async rd1 got %h exp 0", rd1); end
        if (rd2 !== 32'h0) begin fails++; $display("FAIL rstmid async rd2 got %h exp 0", rd2); end
        if (wb_en !== 1'b0) begin fails++; $display("FAIL rstmid async wb_en got %b exp 0", wb_en); end
        @(negedge clk);
        rstn = 1'b1;
      end
    end
    exp_cnt = 0;
`ifdef WB_REGFILE_COMMIT_CNT_EN
    tests++;
    if (cnt !== exp_cnt) begin fails++; $display("FAIL rstmid commit_cnt got %0d exp %0d", cnt, exp_cnt); end
`endif
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_forward;
    test_zero;
    test_back_to_back;
    test_stall;
    test_flush;
    test_overflow;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the EX-stage result triple: RegWriteEn, RegWriteAddr, RegWriteData.
- Registers that triple in a one-deep WB stage, then commits it into a 32x32 general-purpose register file.
- Serves two combinational read ports to the ID stage, with forwarding from the WB stage and from the live EX result.
- $0 is hardwired to zero.

Parameters:
- DW, 32, data width of each register and of the write data.
- AW, 5, register address width; the file holds 2**AW entries.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- RegWriteEn_i  input  1  EX result write enable (already 0 on ALU overflow)
- RegWriteAddr_i  input  AW  EX result destination register
- RegWriteData_i  input  DW  EX result value
- stall  input  1  upstream stalled: EX inputs are held and must not be captured
- flush  input  1  discard the EX result presented this cycle
- rd_addr1  input  AW  read port 1 address
- rd_addr2  input  AW  read port 2 address
- rd_data1  output  DW  read port 1 data (combinational)
- rd_data2  output  DW  read port 2 data (combinational)
- wb_en_o  output  1  WB stage valid-write flag (for hazard unit)
- wb_addr_o  output  AW  WB stage destination address

Behaviour:
- Reset (rstn=0, asynchronous):
  - wb_en, wb_addr and wb_data clear to 0.
  - All array entries clear to 0.
  - rd_data1/2 read 0 for every address.
  - Reset mid-commit: the pending write is lost.
- WB stage capture, each posedge clk, in priority order:
  - flush=1: wb_en<=0; wb_addr and wb_data may update but are don't-care.
  - else stall=1: wb_en<=0, a bubble. The held EX value is captured on the first non-stalled cycle, so it is committed exactly once.
  - else: wb_en<=RegWriteEn_i, wb_addr<=RegWriteAddr_i, wb_data<=RegWriteData_i.
  - flush and stall together: flush wins.
- Commit, same posedge:
  - If wb_en=1 and wb_addr!=0, then regs[wb_addr]<=wb_data.
  - Writes to address 0 are dropped.
  - Latency: EX result presented at edge N is captured at N, committed at N+1, and is readable from the array after N+1.
- Read, per port, pure combinational, first match wins:
  - 1. rd_addr==0 -> 0.
  - 2. RegWriteEn_i=1, stall=0, flush=0 and RegWriteAddr_i==rd_addr -> RegWriteData_i (EX forward).
  - 3. wb_en=1 and wb_addr==rd_addr -> wb_data (WB forward).
  - 4. Otherwise -> regs[rd_addr].
- Port independence:
  - The two ports are fully independent.
  - Same address on both ports returns identical data.
- Back-to-back writes to the same register:
  - The newer value wins on reads at every cycle: EX over WB over array.
- Overflowed ALU ops arrive with RegWriteEn_i=0. They are never forwarded and never committed, even though the data bus carries a value.
- wb_en_o and wb_addr_o mirror the WB registers directly.

Optional Feature:
- Macro WB_REGFILE_COMMIT_CNT_EN.
- When defined:
  - Adds output commit_cnt, 32 bits, reset to 0.
  - Increments by 1 on every edge where a commit actually occurs (wb_en=1 and wb_addr!=0).
  - Wraps 0xFFFFFFFF -> 0.
  - Writes to $0, bubbles and flushed results do not count.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read returns 0x00000000; wb_en_o=0.
- EX presents en=1, addr=5, data=0x12345678 for one cycle:
  - Same cycle: rd_addr1=5 -> 0x12345678 (EX forward).
  - Next cycle: -> 0x12345678 via WB forward, wb_en_o=1, wb_addr_o=5.
  - Two cycles on: -> 0x12345678 from the array.
- Write addr=0, data=0xFFFFFFFF -> rd_data for address 0 stays 0 in all cycles; commit_cnt unchanged when the macro is defined.
- Back-to-back writes addr=7 with 0xA, then addr=7 with 0xB, rd_addr2=7 held -> reads 0xA, then 0xB (EX beats WB), then 0xB thereafter.
- Stall sequence:
  - Stall held 3 cycles with EX en=1, addr=9, data=0x55: wb_en_o=0 during the stall; register 9 is not written.
  - After release: committed once, and commit_cnt increments by exactly 1.
- Flush with en=1, addr=3, data=0x77 -> register 3 is never updated and is never forwarded.
- Overflow case: en=0, addr=4, data=0x80000000 -> register 4 is unchanged.
